// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-state encoding and frame bit levels for the UART path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Line levels of the framing bits. uart_tx uses the same values.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line, plus a 3-sample history and majority vote.
// Latency: o_sync is 2 clock_out cycles behind i_rdata; o_maj covers the 3 synchronized samples before it.
// Backpressure: none; free-running every clock_out tick.
// Ports: clock_out/nreset clock and async active-low reset; i_rdata raw line;
//        o_sync synchronized line level; o_maj majority of the last 3 synchronized samples.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock_out,
    input  logic nreset,
    input  logic i_rdata,
    output logic o_sync,
    output logic o_maj
);

    logic       r_meta;
    logic       r_sync;
    logic [2:0] r_hist;

    // All flops reset to the idle line level, so a reset never looks like a start edge.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            r_meta <= STOP_BIT;
            r_sync <= STOP_BIT;
            r_hist <= {3{STOP_BIT}};
        end else begin
            r_meta <= i_rdata;
            r_sync <= r_meta;
            r_hist <= {r_hist[1:0], r_sync};
        end
    end

    assign o_sync = r_sync;
    assign o_maj  = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1-style serial receiver with a valid/ack holding register.
// Latency: word appears on data/valid at the stop-bit mid sample (~9.5 bit times after the start edge).
// Backpressure: none on the line; a good frame arriving while valid=1 is dropped and sets sticky overrun.
// Ports: clock_out tick clock (OVERSAMPLING ticks per bit); nreset async active-low; rdata serial line;
//        ack consumer handshake; data/valid holding register; frame_error one-cycle pulse on bad stop bit;
//        overrun sticky drop flag; busy high whenever the FSM is not idle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BYTESIZES    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int BAUDRATE     = 115200
) (
    input  logic                 clock_out,
    input  logic                 nreset,
    input  logic                 rdata,
    input  logic                 ack,
    output logic [BYTESIZES-1:0] data,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(BYTESIZES + 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BYTESIZES - 1);

    // The tick counter relies on natural wrap at OVERSAMPLING, hence the power-of-two rule.
    if (OVERSAMPLING < 4 || (OVERSAMPLING & (OVERSAMPLING - 1)) != 0 || BAUDRATE <= 0) begin : g_bad_param
        $error("uart_rx: OVERSAMPLING must be a power of two >= 4 and BAUDRATE positive");
    end

    rx_state_t            r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [BYTESIZES-1:0] r_shift;
    logic [BYTESIZES-1:0] r_data;
    logic                 r_valid;
    logic                 r_fe;
    logic                 r_ovr;

    logic w_sync;
    logic w_maj;
    logic w_stop_pt;
    logic w_good;

    uart_rx_sync u_sync (
        .clock_out (clock_out),
        .nreset    (nreset),
        .i_rdata   (rdata),
        .o_sync    (w_sync),
        .o_maj     (w_maj)
    );

    assign w_stop_pt = (r_state == STOP) && (r_tick == LAST_TICK);
    assign w_good    = w_stop_pt && (w_maj == STOP_BIT);

    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_fe <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_sync == START_BIT) begin
                        r_tick  <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    // Mid start bit: a majority high here means the low level was a glitch.
                    if (r_tick == HALF_TICK) begin
                        if (w_maj == STOP_BIT) begin
                            r_state <= IDLE;
                        end else begin
                            r_tick  <= '0;
                            r_bit   <= '0;
                            r_state <= DATA;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick == LAST_TICK) begin
                        r_tick  <= '0;
                        r_shift <= {w_maj, r_shift[BYTESIZES-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == LAST_BIT) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is not missed.
                    if (r_tick == LAST_TICK) begin
                        r_tick <= '0;
                        if (w_maj == STOP_BIT) begin
                            r_state <= IDLE;
                        end else begin
                            r_fe    <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_sync == STOP_BIT) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Holding register. An ack on the completion edge frees the slot for the new word.
            if (w_good) begin
                if (ack || !r_valid) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
                if (ack) begin
                    r_ovr <= 1'b0;
                end else if (r_valid) begin
                    r_ovr <= 1'b1;
                end
            end else if (ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign frame_error = r_fe;
    assign overrun     = r_ovr;
    assign busy        = (r_state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path: recovers 8N1-style frames (start bit 0, BYTESIZES data bits LSB first, one stop bit 1) from the asynchronous line. It runs on the oversampled tick clock produced by `baudRateGenerator`, with OVERSAMPLING ticks per bit. Received words are presented on a valid/ack holding register, with framing-error and overrun flags. It is the receive-side counterpart of `uart_tx` and shares its parameter names and frame format.

## Interface
- BYTESIZES, 8: data bits per frame.
- OVERSAMPLING, 16: clock_out ticks per bit. Must be a power of two and ≥ 4. Elaboration fails otherwise.
- BAUDRATE, 115200: informational only. Passed through so both ends share one parameter set.
- clock_out  input  1  oversampled tick clock, rising edge active.
- nreset  input  1  reset, asynchronous, active-low.
- rdata  input  1  serial line, asynchronous to clock_out, idle high.
- ack  input  1  consumer has taken data. Clears valid and overrun.
- data  output  BYTESIZES  last accepted word, LSB = first bit received.
- valid  output  1  data holds an unconsumed word.
- frame_error  output  1  one-cycle pulse when a stop bit samples 0.
- overrun  output  1  sticky. Set when a good frame completes while valid=1.
- busy  output  1  high in every state except IDLE.

## Operation
- Input conditioning:
  - rdata passes through a 2-flop synchronizer, then a 3-deep shift of synchronized samples. All synchronizer and shift flops reset to 1.
  - The bit value used at a sample point is the majority of the 3 most recent synchronized samples.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when the synchronized line reads 0, clear tick_cnt and go to START.
- START: count ticks. At tick_cnt == OVERSAMPLING/2-1, take the majority bit.
  - Majority 1 is a false start: return to IDLE, no flags.
  - Majority 0: clear tick_cnt and bit_cnt, go to DATA.
- DATA: at tick_cnt == OVERSAMPLING-1, shift the majority bit into the MSB of shift_reg (shift right), increment bit_cnt, and wrap tick_cnt to 0. After bit BYTESIZES-1, go to STOP.
- STOP: at tick_cnt == OVERSAMPLING-1, sample the bit.
  - Sample 1, valid=0: data <= shift_reg, valid <= 1, go to IDLE.
  - Sample 1, valid=1: data unchanged (the new word is dropped), overrun <= 1, go to IDLE.
  - Sample 0: frame_error pulses for one cycle, data/valid/overrun unchanged, go to BREAK.
- BREAK: wait until the synchronized line reads 1, then go to IDLE. No start is detected while in BREAK.
- ack: when ack=1, valid <= 0 and overrun <= 0 on the next edge.
  - If ack and a good-frame completion occur on the same edge, the new word is loaded, valid stays 1, and overrun is not set.
- Widths: tick_cnt is $clog2(OVERSAMPLING) bits. bit_cnt is $clog2(BYTESIZES+1) bits. Both are compared unsigned and never wrap outside their stated terminal values.

## Timing
- Reset values: data=0, valid=0, frame_error=0, overrun=0, busy=0, FSM=IDLE.
- Reset asserted mid-frame aborts immediately. Any partial word is discarded.
- Line-to-decision latency: 2 synchronizer cycles plus 1 register cycle.
- Start edge to first data sample: about 1.5 bit times (OVERSAMPLING/2 + OVERSAMPLING ticks).
- valid rises on the clock_out edge that takes the stop sample, about half a bit before the stop bit ends. frame_error pulses on that same edge.
- Back-to-back frames with no idle gap are accepted. IDLE is re-entered mid-stop-bit, so the next falling edge is caught.
- A low glitch shorter than about OVERSAMPLING/2-1 ticks is rejected as a false start.
- All outputs are registered. There is no combinational path from rdata or ack.

## Structure
- Package uart_pkg holds:
  - the typedef enum logic [2:0] for the rx states {IDLE, START, DATA, STOP, BREAK};
  - the frame constants START_BIT=0 and STOP_BIT=1, shared with uart_tx.
- Sub-module uart_rx_sync contains the 2-flop synchronizer, the 3-sample shift register and the majority vote. Output: synced bit plus majority bit.
- The FSM, counters, shift register and the output holding register live in uart_rx.

## Test plan
- Send 0xA5 at OVERSAMPLING=16, with ack held low → data=0xA5, valid=1, frame_error=0, busy returns to 0.
- Drive a 5-tick low pulse on an idle line → no valid, no frame_error, busy high for at most 8 ticks then 0.
- Send 0x3C with stop bit forced to 0, line held low 40 ticks, then 0x11 → one frame_error pulse, FSM stays in BREAK until the line goes high; 0x11 then received with valid=1.
- Send 0x12 then 0x34 with no ack → data=0x12, overrun=1. Pulse ack → valid=0, overrun=0.
- Send 0x55, 0xAA, 0xFF back-to-back with zero idle gap, ack pulsed after each → three valid words in order, no errors.
- Assert nreset during bit 4 of a frame, release, then send 0x81 → all outputs at reset values during reset; 0x81 then received correctly.
